pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter N_RST, default 3: number of staggered reset outputs, legal range 1..8.
REQ-002 SHALL have parameter GLITCH_FILTER, default 4: consecutive synchronised-lock cycles required, minimum 1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: cycles reset is held after the filter passes, minimum 1.
REQ-004 SHALL have parameter STAGGER, default 8: cycles between successive reset releases, minimum 1.
REQ-005 SHALL have parameter CNT_W, default 8: width of the lock-loss counter.
REQ-006 SHALL have port clock, input, 1 bit: single clock, driven by the PLL output.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port lock_in, input, 1 bit: raw PLL LOCK, asynchronous to clock.
REQ-009 SHALL have port clear_count, input, 1 bit: synchronous clear of lock_lost_count.
REQ-010 SHALL have port rst_out, output, N_RST bits: active-high domain resets; bit 0 is released first.
REQ-011 SHALL have port ready, output, 1 bit: all domains released and lock stable.
REQ-012 SHALL have port lock_lost_count, output, CNT_W bits: saturating count of lock losses while in RUN.

Function
REQ-013 SHALL pass lock_in through a 2-flop synchroniser; lock_sync is the stage-2 output, and nothing else uses lock_in.
REQ-014 SHALL implement the states WAIT_LOCK, FILTER, HOLD, RELEASE and RUN, each with one shared down/up counter.
REQ-015 WAIT_LOCK: rst_out all ones and ready=0; on lock_sync=1, go to FILTER with the counter at 1.
REQ-016 FILTER: count consecutive lock_sync=1 cycles; on reaching GLITCH_FILTER, go to HOLD.
REQ-017 HOLD: count HOLD_CYCLES; on reaching HOLD_CYCLES, clear rst_out[0] and go to RELEASE (or RUN if N_RST=1).
REQ-018 RELEASE: every STAGGER cycles, clear the next rst_out bit in ascending index order; when the last bit clears, set ready=1 in the same cycle and enter RUN.
REQ-019 Timing: E0 is the first edge at which stage 1 samples lock_in=1 with lock held.
REQ-020 Timing: rst_out[i] SHALL fall at edge E0+2+GLITCH_FILTER+HOLD_CYCLES+i*STAGGER.
REQ-021 Timing: ready SHALL rise together with rst_out[N_RST-1].
REQ-022 Lock loss: in any state other than WAIT_LOCK, lock_sync=0 SHALL, at the next edge, set rst_out all ones, set ready=0 and enter WAIT_LOCK.
REQ-023 Lock loss: the filter, hold and stagger progress SHALL be discarded, with no partial resumption.
REQ-024 lock_lost_count SHALL increment only on a lock loss detected in RUN, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 clear_count=1 SHALL zero the counter at the next edge.
REQ-026 If clear_count=1 coincides with an increment, the counter SHALL become 1.
REQ-027 rst_out bits, once cleared, SHALL not reassert except on lock loss or rst_n.
REQ-028 rst_out bits SHALL never glitch, because all outputs are registered.
REQ-029 ready SHALL imply rst_out==0, at all times.
REQ-030 Lock glitches shorter than 2 cycles MAY be invisible after the synchroniser; any glitch seen at lock_sync SHALL be honoured per REQ-022.

Reset
REQ-031 rst_n=0 sampled at an edge SHALL set the state to WAIT_LOCK, rst_out to all ones, ready to 0, lock_lost_count to 0 and both synchroniser flops to 0.
REQ-032 rst_n=0 SHALL take priority over lock_in and clear_count.
REQ-033 rst_n=0 SHALL act identically mid-sequence or in RUN.
REQ-034 rst_n=0 SHALL not count as a lock loss.
REQ-035 After rst_n returns to 1, the sequence SHALL restart per REQ-019 to REQ-021, with E0 no earlier than the first edge with rst_n=1.

Verification
REQ-036 Defaults, lock_in held high from E0 -> rst_out 3'b111 until E0+22, then 3'b110 at E0+22, 3'b100 at E0+30, 3'b000 at E0+38, with ready=1 at E0+38; lock_lost_count=0.
REQ-037 Lock drops for 3 cycles during HOLD (E0+10) -> rst_out stays 3'b111, ready stays 0, count stays 0; after lock returns at E1, rst_out[0] falls at E1+22.
REQ-038 In RUN, lock drops for 5 cycles -> rst_out=3'b111 and ready=0 two edges after the drop, count=1; full re-sequence on relock.
REQ-039 CNT_W=2, 5 lock losses in RUN -> count reads 1,2,3,3,3; clear_count pulsed together with a 6th loss -> count=1.
REQ-040 rst_n pulsed low at E0+32 (mid-RELEASE) -> next edge rst_out=3'b111, ready=0, count=0; lock held -> rst_out[0] falls 22 edges after rst_n release.
REQ-041 N_RST=1, GLITCH_FILTER=1, HOLD_CYCLES=1 -> rst_out and ready change at E0+4; a 1-cycle lock_sync dropout during FILTER returns to WAIT_LOCK.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Purpose: waits for the PLL LOCK indication to be stable, holds every clock
// domain in reset for a while longer, then releases the domain resets one
// after another (bit 0 first). Any loss of lock seen after synchronisation
// drops all domains back into reset and restarts the whole sequence. Lock
// losses that happen while fully running are counted (saturating).
//
// Ports:
//   clock           - PLL output clock; the only clock in this block
//   rst_n           - synchronous active-low reset
//   lock_in         - raw PLL LOCK, asynchronous to clock
//   clear_count     - synchronous clear of lock_lost_count
//   rst_out         - N_RST active-high domain resets, bit 0 released first
//   ready           - every domain released and lock stable
//   lock_lost_count - saturating count of lock losses seen while running

module pll_lock_sequencer #(
  parameter int N_RST         = 3,
  parameter int GLITCH_FILTER = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int STAGGER       = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             lock_in,
  input  logic             clear_count,
  output logic [N_RST-1:0] rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] lock_lost_count
);

  // The phase timer is shared by FILTER, HOLD and RELEASE, so it has to
  // hold the largest of the three terminal counts.
  localparam int MAX_FH = (GLITCH_FILTER > HOLD_CYCLES) ? GLITCH_FILTER : HOLD_CYCLES;
  localparam int MAX_T  = (MAX_FH > STAGGER) ? MAX_FH : STAGGER;
  localparam int TW     = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    FILTER,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  logic             lock_meta;
  logic             lock_sync;
  state_t           state_q;
  state_t           state_d;
  logic [TW-1:0]    tmr_q;
  logic [TW-1:0]    tmr_d;
  logic [N_RST-1:0] rst_d;
  logic [N_RST-1:0] rst_shifted;
  logic             ready_d;
  logic             lost_inc;
  logic [CNT_W-1:0] lost_d;

  // Shifting the reset vector left by one clears the lowest still-set bit,
  // because released bits always form a contiguous run starting at bit 0.
  assign rst_shifted = rst_out << 1;

  // Next-state logic. A lock loss outside WAIT_LOCK overrides everything and
  // throws away all filter/hold/stagger progress. The timer counts 1..limit;
  // entering a phase loads 1 so the entry edge counts as the first cycle.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    rst_d    = rst_out;
    ready_d  = ready;
    lost_inc = 1'b0;

    if (state_q != WAIT_LOCK && !lock_sync) begin
      state_d  = WAIT_LOCK;
      tmr_d    = '0;
      rst_d    = '1;
      ready_d  = 1'b0;
      lost_inc = (state_q == RUN);
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rst_d   = '1;
          ready_d = 1'b0;
          if (lock_sync) begin
            state_d = FILTER;
            tmr_d   = TW'(1);
          end
        end

        FILTER: begin
          if (tmr_q == TW'(GLITCH_FILTER)) begin
            state_d = HOLD;
            tmr_d   = TW'(1);
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end

        // HOLD and RELEASE both end by releasing one more domain; when that
        // was the last one, ready rises on the same edge.
        HOLD, RELEASE: begin
          if ((state_q == HOLD    && tmr_q == TW'(HOLD_CYCLES)) ||
              (state_q == RELEASE && tmr_q == TW'(STAGGER))) begin
            rst_d = rst_shifted;
            tmr_d = TW'(1);
            if (rst_shifted == '0) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end

        RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end

        default: begin
          state_d = WAIT_LOCK;
          tmr_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // Lock-loss counter: a clear coinciding with a new loss leaves exactly
  // that one loss recorded; otherwise increments saturate at all ones.
  always_comb begin
    lost_d = lock_lost_count;
    if (clear_count) begin
      lost_d = lost_inc ? CNT_W'(1) : '0;
    end else if (lost_inc && lock_lost_count != '1) begin
      lost_d = lock_lost_count + CNT_W'(1);
    end
  end

  // All state, including both synchroniser flops, is registered here so the
  // outputs never glitch. Reset also clears the synchroniser, so a lock that
  // was already high is only seen from the first edge after reset lifts.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      lock_meta       <= 1'b0;
      lock_sync       <= 1'b0;
      state_q         <= WAIT_LOCK;
      tmr_q           <= '0;
      rst_out         <= '1;
      ready           <= 1'b0;
      lock_lost_count <= '0;
    end else begin
      lock_meta       <= lock_in;
      lock_sync       <= lock_meta;
      state_q         <= state_d;
      tmr_q           <= tmr_d;
      rst_out         <= rst_d;
      ready           <= ready_d;
      lock_lost_count <= lost_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//
// Purpose: directed, self-checking bench for pll_lock_sequencer. Three
// instances are exercised one after another: default parameters (table of
// vectors), CNT_W=2 (saturation and clear), and N_RST=1 with the shortest
// filter/hold (minimum-latency path and FILTER dropout).

module tb_pll_lock_sequencer;

  logic       clock;

  logic       rst_n_a;
  logic       lock_a;
  logic       clr_a;
  logic [2:0] rst_out_a;
  logic       ready_a;
  logic [7:0] cnt_a;

  logic       rst_n_c;
  logic       lock_c;
  logic       clr_c;
  logic [2:0] rst_out_c;
  logic       ready_c;
  logic [1:0] cnt_c;

  logic       rst_n_s;
  logic       lock_s;
  logic       clr_s;
  logic [0:0] rst_out_s;
  logic       ready_s;
  logic [7:0] cnt_s;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    int         cycles;
    logic       lock;
    logic       clr;
    logic       rstn;
    logic [2:0] exp_rst;
    logic       exp_ready;
    logic [7:0] exp_cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  pll_lock_sequencer dut (
    .clock           (clock),
    .rst_n           (rst_n_a),
    .lock_in         (lock_a),
    .clear_count     (clr_a),
    .rst_out         (rst_out_a),
    .ready           (ready_a),
    .lock_lost_count (cnt_a)
  );

  pll_lock_sequencer #(.CNT_W(2)) dut_c (
    .clock           (clock),
    .rst_n           (rst_n_c),
    .lock_in         (lock_c),
    .clear_count     (clr_c),
    .rst_out         (rst_out_c),
    .ready           (ready_c),
    .lock_lost_count (cnt_c)
  );

  pll_lock_sequencer #(.N_RST(1), .GLITCH_FILTER(1), .HOLD_CYCLES(1)) dut_s (
    .clock           (clock),
    .rst_n           (rst_n_s),
    .lock_in         (lock_s),
    .clear_count     (clr_s),
    .rst_out         (rst_out_s),
    .ready           (ready_s),
    .lock_lost_count (cnt_s)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one active edge and settle just after it, so inputs set now are
  // seen at the next edge and outputs read now reflect the edge just passed.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    lock_a  = v.lock;
    clr_a   = v.clr;
    rst_n_a = v.rstn;
    repeat (v.cycles) tick();
  endtask

  task automatic addVec(input int cycles, input logic lock, input logic clr, input logic rstn,
                        input logic [2:0] exp_rst, input logic exp_ready, input logic [7:0] exp_cnt,
                        input string name);
    vec_t v;
    v.cycles    = cycles;
    v.lock      = lock;
    v.clr       = clr;
    v.rstn      = rstn;
    v.exp_rst   = exp_rst;
    v.exp_ready = exp_ready;
    v.exp_cnt   = exp_cnt;
    v.name      = name;
    vecs.push_back(v);
  endtask

  initial begin
    int exp_lost[5];
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n_a = 1'b0; lock_a = 1'b0; clr_a = 1'b0;
    rst_n_c = 1'b0; lock_c = 1'b0; clr_c = 1'b0;
    rst_n_s = 1'b0; lock_s = 1'b0; clr_s = 1'b0;

    // Default instance. Edge numbers in names are relative to the edge where
    // stage 1 first samples lock high (E0, E1, ...).
    addVec( 2, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0, "reset");
    addVec( 1, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0, "e0");
    addVec(21, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0, "e0_21");
    addVec( 1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd0, "e0_22");
    addVec( 7, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd0, "e0_29");
    addVec( 1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 8'd0, "e0_30");
    addVec( 7, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 8'd0, "e0_37");
    addVec( 1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 8'd0, "e0_38");
    // Lock drops in RUN for 5 cycles: visible to the FSM two edges later.
    addVec( 1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 8'd0, "run_drop_d0");
    addVec( 1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 8'd0, "run_drop_d1");
    addVec( 1, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 8'd1, "run_drop_d2");
    addVec( 2, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 8'd1, "run_drop_d4");
    addVec(22, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd1, "e1_21");
    addVec( 1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd1, "e1_22");
    addVec( 8, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 8'd1, "e1_30");
    addVec( 1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 8'd1, "e1_31");
    // rst_n pulsed mid-RELEASE with lock high and clear low.
    addVec( 1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0, "rstn_mid_release");
    addVec(22, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0, "e2_21");
    addVec( 1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd0, "e2_22");
    // Fresh start, then a 3-cycle lock drop during HOLD.
    addVec( 1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0, "rstn_again");
    addVec(10, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0, "e3_9");
    addVec( 3, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0, "hold_drop");
    addVec(22, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0, "e4_21");
    addVec( 1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 8'd0, "e4_22");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_rst"},   32'(rst_out_a), 32'(vecs[i].exp_rst));
      checkOutput({vecs[i].name, "_ready"}, 32'(ready_a),   32'(vecs[i].exp_ready));
      checkOutput({vecs[i].name, "_count"}, 32'(cnt_a),     32'(vecs[i].exp_cnt));
    end

    // CNT_W=2 instance: reach RUN, then five losses saturate at 3.
    exp_lost = '{1, 2, 3, 3, 3};
    tick();
    rst_n_c = 1'b1;
    lock_c  = 1'b1;
    repeat (39) tick();
    checkOutput("c_first_ready", 32'(ready_c),   32'd1);
    checkOutput("c_first_rst",   32'(rst_out_c), 32'd0);
    for (int i = 0; i < 5; i++) begin
      lock_c = 1'b0;
      tick();
      tick();
      lock_c = 1'b1;
      tick();
      checkOutput($sformatf("c_loss%0d_count", i + 1), 32'(cnt_c), 32'(exp_lost[i]));
      checkOutput($sformatf("c_loss%0d_ready", i + 1), 32'(ready_c), 32'd0);
      repeat (38) tick();
      checkOutput($sformatf("c_relock%0d_ready", i + 1), 32'(ready_c), 32'd1);
    end
    lock_c = 1'b0;
    tick();
    tick();
    lock_c = 1'b1;
    clr_c  = 1'b1;
    tick();
    clr_c  = 1'b0;
    checkOutput("c_clear_with_loss", 32'(cnt_c), 32'd1);
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    checkOutput("c_clear_plain", 32'(cnt_c), 32'd0);

    // N_RST=1, GLITCH_FILTER=1, HOLD_CYCLES=1: release lands at E0+4.
    rst_n_s = 1'b1;
    lock_s  = 1'b1;
    tick();
    repeat (3) tick();
    checkOutput("s_e0_3_rst",   32'(rst_out_s), 32'd1);
    checkOutput("s_e0_3_ready", 32'(ready_s),   32'd0);
    tick();
    checkOutput("s_e0_4_rst",   32'(rst_out_s), 32'd0);
    checkOutput("s_e0_4_ready", 32'(ready_s),   32'd1);
    rst_n_s = 1'b0;
    tick();
    checkOutput("s_reset_rst", 32'(rst_out_s), 32'd1);
    // One-cycle dropout that lock_sync shows while the FSM is in FILTER;
    // the sequence restarts from the edge where lock returns.
    rst_n_s = 1'b1;
    lock_s  = 1'b1;
    tick();
    lock_s = 1'b0;
    tick();
    lock_s = 1'b1;
    tick();
    repeat (3) tick();
    checkOutput("s_dropout_e3_rst",   32'(rst_out_s), 32'd1);
    checkOutput("s_dropout_e3_ready", 32'(ready_s),   32'd0);
    tick();
    checkOutput("s_dropout_e4_rst",   32'(rst_out_s), 32'd0);
    checkOutput("s_dropout_e4_ready", 32'(ready_s),   32'd1);
    checkOutput("s_count",            32'(cnt_s),     32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
